// File: rtl/ccg_truth_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module   : ccg_truth_sweeper_if
// Brief    : Sweep control, benchmark drive/sample and row handshake bundle
//            shared between the truth-table sweeper and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface ccg_truth_sweeper_if #(
    parameter int NIN  = 4,
    parameter int NOUT = 18
);
    logic            start;
    logic            abort;
    logic [NIN-1:0]  x;
    logic [NOUT-1:0] f;
    logic            row_valid;
    logic            row_ready;
    logic [NIN-1:0]  row_addr;
    logic [NOUT-1:0] row_data;
    logic            busy;
    logic            done;
    logic [31:0]     signature;

    // Environment side: requests sweeps, models the benchmark, consumes rows
    modport master (
        output start, abort, f, row_ready,
        input  x, row_valid, row_addr, row_data, busy, done, signature
    );

    // Sweeper side
    modport slave (
        input  start, abort, f, row_ready,
        output x, row_valid, row_addr, row_data, busy, done, signature
    );
endinterface
`default_nettype wire

// File: rtl/ccg_truth_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : ccg_truth_sweeper
// Brief    : Drives every input pattern of a combinational benchmark, waits
//            SETTLE cycles, captures the outputs as a truth-table row, hands
//            it out over a valid/ready port and compacts all rows in a MISR.
// Revision : 1.0 - initial release
// ============================================================================
module ccg_truth_sweeper #(
    parameter int NIN    = 4,
    parameter int NOUT   = 18,
    parameter int SETTLE = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    ccg_truth_sweeper_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRIVE = 2'd1;
    localparam logic [1:0] c_EMIT  = 2'd2;
    localparam logic [1:0] c_FIN   = 2'd3;

    localparam logic [3:0]     c_LAST_CNT = 4'(SETTLE - 1);
    localparam logic [NIN-1:0] c_X_MAX    = {NIN{1'b1}};
    localparam logic [31:0]    c_POLY     = 32'h04C11DB7;

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic [NIN-1:0]  r_x;
    logic            r_row_valid;
    logic [NIN-1:0]  r_row_addr;
    logic [NOUT-1:0] r_row_data;
    logic            r_done;
    logic [31:0]     r_sig;
    logic [31:0]     w_fold;
    logic [31:0]     w_sig_next;

    // Fold f into 32 bits (bits above 31 XOR onto the low bits), then step the MISR
    always_comb begin
        w_fold = '0;
        for (int i = 0; i < NOUT; i++) begin
            w_fold[i[4:0]] = w_fold[i[4:0]] ^ bus.f[i];
        end
        w_sig_next = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? c_POLY : 32'h0) ^ w_fold;
    end

    // Sweep sequencer: IDLE -> (DRIVE -> EMIT) per pattern -> FIN -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_x         <= '0;
            r_row_valid <= 1'b0;
            r_row_addr  <= '0;
            r_row_data  <= '0;
            r_done      <= 1'b0;
            r_sig       <= 32'hFFFFFFFF;
        end else begin
            r_done <= 1'b0;
            if (bus.abort && (r_state != c_IDLE)) begin
                // Cancel keeps the partial signature and captured row registers
                r_state     <= c_IDLE;
                r_cnt       <= '0;
                r_x         <= '0;
                r_row_valid <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (bus.start && !bus.abort) begin
                            r_x     <= '0;
                            r_cnt   <= '0;
                            r_sig   <= 32'hFFFFFFFF;
                            r_state <= c_DRIVE;
                        end
                    end
                    c_DRIVE: begin
                        if (r_cnt == c_LAST_CNT) begin
                            r_row_data  <= bus.f;
                            r_row_addr  <= r_x;
                            r_sig       <= w_sig_next;
                            r_row_valid <= 1'b1;
                            r_state     <= c_EMIT;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                    c_EMIT: begin
                        if (bus.row_ready) begin
                            r_row_valid <= 1'b0;
                            if (r_x == c_X_MAX) begin
                                // Last pattern: x stays at its maximum, no wrap
                                r_done  <= 1'b1;
                                r_state <= c_FIN;
                            end else begin
                                r_x     <= r_x + NIN'(1);
                                r_cnt   <= '0;
                                r_state <= c_DRIVE;
                            end
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_x     <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.x         = r_x;
    assign bus.row_valid = r_row_valid;
    assign bus.row_addr  = r_row_addr;
    assign bus.row_data  = r_row_data;
    assign bus.busy      = (r_state != c_IDLE);
    assign bus.done      = r_done;
    assign bus.signature = r_sig;

endmodule
`default_nettype wire

// File: doc/ccg_truth_sweeper.md
CCG_TRUTH_SWEEPER -- requirements
Module: ccg_truth_sweeper

Interface
REQ-001 Parameters (one per line: name, default, meaning):
- NIN, 4, width of the benchmark input vector driven to the circuit under test.
- NOUT, 18, width of the benchmark output vector sampled from the circuit under test.
- SETTLE, 1, cycles `x` is held stable before `f` is sampled; legal range 1..15.
REQ-002 Ports (one per line: name, direction, width, meaning):
- clk, in, 1, sole clock; all state updates on the rising edge.
- rst, in, 1, reset; synchronous and active-high.
- start, in, 1, one-cycle request to begin an exhaustive sweep.
- abort, in, 1, synchronous cancel of a running sweep.
- x, out, NIN, input pattern driven to the combinational benchmark (x[0] maps to benchmark input x0).
- f, in, NOUT, benchmark outputs (f[0] maps to benchmark output f1).
- row_valid, out, 1, a captured truth-table row is presented.
- row_ready, in, 1, the consumer accepts the row.
- row_addr, out, NIN, input pattern of the presented row.
- row_data, out, NOUT, sampled `f` for that row.
- busy, out, 1, a sweep is in progress.
- done, out, 1, one-cycle pulse when a sweep completes normally.
- signature, out, 32, MISR compaction of all rows of the last sweep.

Function
REQ-003 The block SHALL implement the FSM states IDLE, DRIVE, EMIT and FIN.
REQ-004 In IDLE, the block SHALL hold `x` at 0.
REQ-005 In IDLE, `start`=1 SHALL set `x` to 0, clear the settle counter, load `signature` with 32'hFFFFFFFF and enter DRIVE.
REQ-006 In DRIVE, the block SHALL count SETTLE cycles with `x` stable; on the final count it SHALL:
- latch `f` into `row_data` and `x` into `row_addr`;
- update `signature`;
- enter EMIT.
REQ-007 The MISR update SHALL be: sig_next = ({sig[30:0],1'b0} ^ (sig[31] ? 32'h04C11DB7 : 0)) ^ zero-extend(f).
- When NOUT exceeds 32, the bits of `f` above bit 31 SHALL be XOR-folded into bits [NOUT-33:0] before the update.
REQ-008 In EMIT, `row_valid` SHALL be 1.
- `row_addr`, `row_data` and `x` SHALL be held stable until `row_valid`&&`row_ready` is sampled 1.
- The block SHALL NOT drop or duplicate a row.
REQ-009 On acceptance in EMIT with `x` != 2^NIN-1, the block SHALL increment `x` by 1 and return to DRIVE with the settle counter cleared.
REQ-010 On acceptance in EMIT with `x` == 2^NIN-1, the block SHALL enter FIN.
- `x` SHALL NOT wrap to 0 during the sweep.
REQ-011 FIN SHALL last one cycle, assert `done`=1 and then return to IDLE.
REQ-012 `signature` SHALL hold its final value until the next accepted `start`.
REQ-013 `busy` SHALL be 1 in DRIVE, EMIT and FIN, and 0 in IDLE.
REQ-014 `start` SHALL be ignored while `busy`=1.
REQ-015 `abort`=1 in any state other than IDLE SHALL force IDLE on the next edge.
- `row_valid`=0 and `x`=0 after the abort.
- No `done` pulse SHALL be produced.
- `signature` SHALL keep its partial value.
REQ-016 If `abort` and `start` are both 1 in IDLE, `abort` SHALL take priority and the block SHALL stay in IDLE.
REQ-017 A full sweep with `row_ready` tied to 1 SHALL take exactly 2^NIN*(SETTLE+1)+1 cycles from the `start` edge to the `done` pulse.
- For the defaults this is 33 cycles.
REQ-018 The block SHALL treat `f` as purely combinational in `x`; no other timing assumption is made about the circuit under test.

Reset
REQ-019 While `rst`=1, the block SHALL:
- enter IDLE;
- drive `x`=0, `row_valid`=0, `row_addr`=0, `row_data`=0, `busy`=0, `done`=0 and `signature`=32'hFFFFFFFF.
REQ-020 `rst` SHALL override `start` and `abort`.
REQ-021 A reset asserted mid-sweep SHALL discard the sweep with no `done` pulse and no further rows presented.

Verification
REQ-022 Defaults, `row_ready`=1, `f`={14'b0,x}: exactly 16 rows SHALL be presented.
- `row_addr` SHALL be 0..15 in order, with `row_data`==`row_addr` on each row.
- `done` SHALL pulse 33 cycles after `start`.
- `signature` SHALL match the reference-model MISR.
REQ-023 `row_ready` held 0 for 5 cycles on row 7: `row_valid` SHALL stay 1 and `x`/`row_addr`/`row_data` SHALL stay stable at 7 throughout.
- Row 8 SHALL appear only after acceptance.
- Total sweep time SHALL be 38 cycles.
REQ-024 `start` pulsed again while on row 3: no effect; the sweep SHALL complete with exactly 16 rows.
REQ-025 `abort` during row 10 EMIT: on the next cycle `busy`=0, `x`=0 and `row_valid`=0, with no `done` pulse.
- A fresh `start` then SHALL produce rows 0..15 and a signature equal to a clean sweep's.
REQ-026 SETTLE=3 with `f` changing only on the second cycle after `x` changes: every `row_data` SHALL reflect the settled value.
- `done` SHALL pulse at cycle 65.
REQ-027 `rst` asserted during row 5 DRIVE: on the next cycle all outputs SHALL be at their REQ-019 values and no further rows SHALL be presented.
